triangle_rasterizer: RTL and testbench
======================================

Name: triangle_rasterizer

Overview:
- Initiator side of the point/z interface served by the z interpolation block.
- Accepts one Triangle3D per handshake and walks its screen-clamped bounding box in row-major order.
- For each pixel it tests coverage, drives the pixel as a point to the interpolator, and samples the returned z.
- Emits covered pixels as fragments (x, y, z) on a valid/ready stream to the depth/framebuffer stage.

Parameters:
- SCREEN_W, 640, screen width in pixels; x clamped to 0..SCREEN_W-1.
- SCREEN_H, 480, screen height in pixels; y clamped to 0..SCREEN_H-1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock, asynchronous, active-low.
- tri_in  in  Triangle3D  triangle; vertices p, q, r each have x, y (16-bit signed) and z (8-bit unsigned).
- tri_valid  in  1  tri_in valid.
- tri_ready  out  1  block can accept a triangle.
- interp_tri  out  Triangle3D  registered copy of the accepted triangle, to the interpolator.
- interp_point  out  Point2D  current pixel, to the interpolator.
- interp_z  in  8  z returned combinationally by the interpolator for interp_point.
- frag_x  out  16  fragment x.
- frag_y  out  16  fragment y.
- frag_z  out  8  fragment z.
- frag_valid  out  1  fragment valid.
- frag_ready  in  1  downstream accepts fragment.
- busy  out  1  high from triangle accept until done.
- done  out  1  one-cycle pulse when a triangle finishes.

Behaviour:
- Reset values: state IDLE; tri_ready=1, frag_valid=0, done=0, busy=0; frag_x/y/z=0; interp_tri=0; interp_point=0.
- IDLE:
  - tri_ready=1.
  - tri_valid&&tri_ready: register triangle, go to SETUP.
- SETUP (1 cycle):
  - Compute sarea2 with the 32-bit signed shoelace formula (pxqy+qxry+rxpy-qxpy-rxqy-pxry).
  - Compute bbox = min/max of the vertex x and y, clamped to the screen.
  - If sarea2==0, or the bbox is empty after clamping (xmin>xmax or ymin>ymax): go to DONE.
  - Otherwise set cur=(xmin,ymin) and go to SCAN.
- SCAN (1 cycle per pixel):
  - interp_point=cur.
  - Compute three 32-bit edge functions E_pq, E_qr, E_rp at cur.
  - Covered iff every E is 0 or has the same sign as sarea2. Edges are inclusive, so shared edges produce duplicates; this is accepted.
  - Covered: latch frag_x/y=cur and frag_z=interp_z in the same cycle, then go to EMIT.
  - Not covered: advance cur.
- Advance rule:
  - x++.
  - If x>xmax: x=xmin, y++.
  - If y>ymax afterwards: go to DONE.
- EMIT:
  - frag_valid=1. Outputs are held stable while frag_ready=0.
  - On frag_valid&&frag_ready: advance cur, then either go to SCAN or go to DONE with frag_valid=0.
- DONE: done=1 for one cycle, then return to IDLE.
- Throughput and latency:
  - At most one fragment per 2 cycles.
  - First fragment valid no earlier than 3 cycles after the triangle handshake.
- tri_ready=0 in every state except IDLE; tri_valid is ignored there.
- busy=1 in SETUP, SCAN, EMIT and DONE.
- Asynchronous reset mid-triangle:
  - Aborts immediately, returns to reset values, no done pulse.
  - A partially emitted triangle is not resumed.
- Width rules:
  - Cursor is 16-bit signed.
  - Bbox clamp is applied before iteration, so no cursor overflow is possible.

Optional Feature:
- Macro: BACKFACE_CULL_EN.
- Defined: SETUP treats sarea2<0 (clockwise winding) like a degenerate triangle; no fragments, done pulses.
- Undefined: both windings are rasterized; coverage uses the sign of sarea2 as above.

Decomposition:
- Shared package:
  - Triangle3D and Point2D typedefs (already shared).
  - New Fragment typedef {x, y, z}.
  - Rasterizer state enum.
  - Default SCREEN_W/SCREEN_H constants.
- Sub-module edge_function: combinational, a, b, c Point2D in, 32-bit signed out. Instantiated three times for coverage and once for sarea2.

Test Plan:
- Basic coverage: tri (0,0),(4,0),(0,4), bench interpolator model z=x+y, frag_ready=1 -> exactly 15 fragments, row-major from (0,0), each with frag_z==x+y, then one done pulse.
- Degenerate: tri (0,0),(2,2),(4,4) -> zero fragments; done 2 cycles after accept; tri_ready high again the next cycle.
- Clipping: SCREEN_W=SCREEN_H=16, tri (-10,-10),(20,-10),(-10,20) -> 66 fragments, all with 0<=x,y and x+y<=10; none with negative coordinates.
- Backpressure: basic triangle with frag_ready low for 5 cycles on the 3rd fragment -> frag_x/y/z and frag_valid stable throughout; total still 15, no duplicates or drops.
- Reset mid-scan: assert reset_n=0 after the 4th fragment -> all outputs take reset values asynchronously; no done pulse; a new triangle after release rasterizes fully.
- Winding (BACKFACE_CULL_EN): tri (0,0),(0,4),(4,0) -> 0 fragments with the macro defined; 15 fragments without it.

Source files
------------

// File: rtl/triangle_rasterizer_pkg.sv
// Shared types for the rasterizer: triangle/point/fragment structs, FSM states, screen defaults.
// Pure declarations plus small min/max helpers; no logic of its own.
package triangle_rasterizer_pkg;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
    } point2d_t;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [7:0]         z;
    } vertex3d_t;

    typedef struct packed {
        vertex3d_t p;
        vertex3d_t q;
        vertex3d_t r;
    } triangle3d_t;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [7:0]         z;
    } fragment_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } rast_state_e;

    function automatic logic signed [15:0] min3(input logic signed [15:0] a,
                                                input logic signed [15:0] b,
                                                input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic signed [15:0] max3(input logic signed [15:0] a,
                                                input logic signed [15:0] b,
                                                input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/triangle_rasterizer_if.sv
// Triangle input, interpolator point/z exchange and fragment stream of the rasterizer.
// master = rasterizer side, slave = its environment (source, interpolator, depth stage).
interface triangle_rasterizer_if;
    import triangle_rasterizer_pkg::*;

    triangle3d_t        tri_in;
    logic               tri_valid;
    logic               tri_ready;
    triangle3d_t        interp_tri;
    point2d_t           interp_point;
    logic [7:0]         interp_z;
    logic signed [15:0] frag_x;
    logic signed [15:0] frag_y;
    logic [7:0]         frag_z;
    logic               frag_valid;
    logic               frag_ready;
    logic               busy;
    logic               done;

    modport master (
        input  tri_in, tri_valid, interp_z, frag_ready,
        output tri_ready, interp_tri, interp_point,
               frag_x, frag_y, frag_z, frag_valid, busy, done
    );

    modport slave (
        output tri_in, tri_valid, interp_z, frag_ready,
        input  tri_ready, interp_tri, interp_point,
               frag_x, frag_y, frag_z, frag_valid, busy, done
    );

endinterface

// File: rtl/triangle_rasterizer_edge_function.sv
// Combinational 2D edge function (b-a) x (c-a) in 32-bit signed arithmetic.
// Zero latency; no handshake.
module triangle_rasterizer_edge_function
    import triangle_rasterizer_pkg::*;
(
    input  point2d_t           a,
    input  point2d_t           b,
    input  point2d_t           c,
    output logic signed [31:0] e
);

    logic signed [31:0] bax, bay, cax, cay;

    assign bax = 32'($signed(b.x)) - 32'($signed(a.x));
    assign bay = 32'($signed(b.y)) - 32'($signed(a.y));
    assign cax = 32'($signed(c.x)) - 32'($signed(a.x));
    assign cay = 32'($signed(c.y)) - 32'($signed(a.y));
    assign e   = bax * cay - bay * cax;

endmodule

// File: rtl/triangle_rasterizer.sv
// Walks a triangle's screen-clamped bbox row-major, emits covered pixels with interpolated z; BACKFACE_CULL_EN drops clockwise triangles.
// First fragment 3 cycles after accept, at most one per 2 cycles; fragment held stable while frag_ready is low.
module triangle_rasterizer
    import triangle_rasterizer_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input logic                   clk,
    input logic                   reset_n,
    triangle_rasterizer_if.master bus
);

    localparam logic signed [15:0] X_HI = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] Y_HI = 16'(SCREEN_H - 1);

    rast_state_e        state_q, state_d;
    triangle3d_t        tri_q, tri_d;
    point2d_t           cur_q, cur_d;
    logic signed [15:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic signed [15:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic signed [31:0] sarea_q, sarea_d;
    fragment_t          frag_q, frag_d;
    logic               frag_vld_q, frag_vld_d;

    point2d_t           pt_p, pt_q, pt_r;
    logic signed [31:0] area_now, e_pq, e_qr, e_rp;
    logic signed [15:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic               degenerate, covered;
    point2d_t           adv_pt;
    logic               adv_end;

    assign pt_p = '{x: tri_q.p.x, y: tri_q.p.y};
    assign pt_q = '{x: tri_q.q.x, y: tri_q.q.y};
    assign pt_r = '{x: tri_q.r.x, y: tri_q.r.y};

    triangle_rasterizer_edge_function u_area (.a(pt_p), .b(pt_q), .c(pt_r),  .e(area_now));
    triangle_rasterizer_edge_function u_e_pq (.a(pt_p), .b(pt_q), .c(cur_q), .e(e_pq));
    triangle_rasterizer_edge_function u_e_qr (.a(pt_q), .b(pt_r), .c(cur_q), .e(e_qr));
    triangle_rasterizer_edge_function u_e_rp (.a(pt_r), .b(pt_p), .c(cur_q), .e(e_rp));

    // Only the screen-facing side of each bound is clamped, so an off-screen triangle yields an empty box.
    always_comb begin
        bb_xmin = min3(tri_q.p.x, tri_q.q.x, tri_q.r.x);
        bb_xmax = max3(tri_q.p.x, tri_q.q.x, tri_q.r.x);
        bb_ymin = min3(tri_q.p.y, tri_q.q.y, tri_q.r.y);
        bb_ymax = max3(tri_q.p.y, tri_q.q.y, tri_q.r.y);
        if (bb_xmin < 0)    bb_xmin = '0;
        if (bb_ymin < 0)    bb_ymin = '0;
        if (bb_xmax > X_HI) bb_xmax = X_HI;
        if (bb_ymax > Y_HI) bb_ymax = Y_HI;
`ifdef BACKFACE_CULL_EN
        degenerate = (area_now <= 0);
`else
        degenerate = (area_now == 0);
`endif
    end

    always_comb begin
        if (!sarea_q[31]) covered = (e_pq >= 0) && (e_qr >= 0) && (e_rp >= 0);
        else              covered = (e_pq <= 0) && (e_qr <= 0) && (e_rp <= 0);
        adv_pt.x = cur_q.x + 16'sd1;
        adv_pt.y = cur_q.y;
        if (adv_pt.x > xmax_q) begin
            adv_pt.x = xmin_q;
            adv_pt.y = cur_q.y + 16'sd1;
        end
        adv_end = (adv_pt.y > ymax_q);
    end

    always_comb begin
        state_d    = state_q;
        tri_d      = tri_q;
        cur_d      = cur_q;
        xmin_d     = xmin_q;
        xmax_d     = xmax_q;
        ymin_d     = ymin_q;
        ymax_d     = ymax_q;
        sarea_d    = sarea_q;
        frag_d     = frag_q;
        frag_vld_d = frag_vld_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.tri_valid) begin
                    tri_d   = bus.tri_in;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                sarea_d = area_now;
                xmin_d  = bb_xmin;
                xmax_d  = bb_xmax;
                ymin_d  = bb_ymin;
                ymax_d  = bb_ymax;
                if (degenerate || (bb_xmin > bb_xmax) || (bb_ymin > bb_ymax)) begin
                    state_d = ST_DONE;
                end else begin
                    cur_d   = '{x: bb_xmin, y: bb_ymin};
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (covered) begin
                    frag_d     = '{x: cur_q.x, y: cur_q.y, z: bus.interp_z};
                    frag_vld_d = 1'b1;
                    state_d    = ST_EMIT;
                end else if (adv_end) begin
                    state_d = ST_DONE;
                end else begin
                    cur_d = adv_pt;
                end
            end
            ST_EMIT: begin
                if (bus.frag_ready) begin
                    frag_vld_d = 1'b0;
                    if (adv_end) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = adv_pt;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tri_q      <= '0;
            cur_q      <= '0;
            xmin_q     <= '0;
            xmax_q     <= '0;
            ymin_q     <= '0;
            ymax_q     <= '0;
            sarea_q    <= '0;
            frag_q     <= '0;
            frag_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tri_q      <= tri_d;
            cur_q      <= cur_d;
            xmin_q     <= xmin_d;
            xmax_q     <= xmax_d;
            ymin_q     <= ymin_d;
            ymax_q     <= ymax_d;
            sarea_q    <= sarea_d;
            frag_q     <= frag_d;
            frag_vld_q <= frag_vld_d;
        end
    end

    assign bus.tri_ready    = (state_q == ST_IDLE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.interp_tri   = tri_q;
    assign bus.interp_point = cur_q;
    assign bus.frag_x       = frag_q.x;
    assign bus.frag_y       = frag_q.y;
    assign bus.frag_z       = frag_q.z;
    assign bus.frag_valid   = frag_vld_q;

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Directed + randomized bench for triangle_rasterizer on a 16x16 screen, interpolator modelled as z = x + y.
module tb_triangle_rasterizer;
    import triangle_rasterizer_pkg::*;

    localparam int TB_W = 16;
    localparam int TB_H = 16;

    logic clk;
    logic reset_n;

    triangle_rasterizer_if bus ();

    triangle_rasterizer #(.SCREEN_W(TB_W), .SCREEN_H(TB_H)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.interp_z = 8'(bus.interp_point.x + bus.interp_point.y);

    int        n_vec;
    int        n_err;
    fragment_t got_q[$];
    fragment_t exp_q[$];
    int        done_cnt;
    int        done_cyc;
    int        first_vld_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic triangle3d_t mk_tri(input int px, input int py, input int qx,
                                           input int qy, input int rx, input int ry);
        triangle3d_t t;
        t = '0;
        t.p.x = 16'(px); t.p.y = 16'(py);
        t.q.x = 16'(qx); t.q.y = 16'(qy);
        t.r.x = 16'(rx); t.r.y = 16'(ry);
        return t;
    endfunction

    // Shoelace double-area of (a,b,c); its sign gives the side of edge a->b that c lies on.
    function automatic int area2(input int ax, input int ay, input int bx, input int by,
                                 input int cx, input int cy);
        return ax*by + bx*cy + cx*ay - bx*ay - cx*by - ax*cy;
    endfunction

    function automatic bit same_side(input int e, input int a);
        return (e == 0) || ((e > 0) == (a > 0));
    endfunction

    function automatic void build_expected(input triangle3d_t t);
        int px, py, qx, qy, rx, ry, a, xmin, xmax, ymin, ymax;
        px = t.p.x; py = t.p.y; qx = t.q.x; qy = t.q.y; rx = t.r.x; ry = t.r.y;
        exp_q.delete();
        a = area2(px, py, qx, qy, rx, ry);
        if (a == 0) return;
`ifdef BACKFACE_CULL_EN
        if (a < 0) return;
`endif
        xmin = (px < qx) ? px : qx; xmin = (rx < xmin) ? rx : xmin;
        xmax = (px > qx) ? px : qx; xmax = (rx > xmax) ? rx : xmax;
        ymin = (py < qy) ? py : qy; ymin = (ry < ymin) ? ry : ymin;
        ymax = (py > qy) ? py : qy; ymax = (ry > ymax) ? ry : ymax;
        if (xmin < 0) xmin = 0;
        if (ymin < 0) ymin = 0;
        if (xmax > TB_W - 1) xmax = TB_W - 1;
        if (ymax > TB_H - 1) ymax = TB_H - 1;
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                if (same_side(area2(px, py, qx, qy, x, y), a) &&
                    same_side(area2(qx, qy, rx, ry, x, y), a) &&
                    same_side(area2(rx, ry, px, py, x, y), a))
                    exp_q.push_back('{x: 16'(x), y: 16'(y), z: 8'(x + y)});
            end
        end
    endfunction

    task automatic check_reset_state();
        check("rst_tri_ready",    32'(bus.tri_ready), 1);
        check("rst_busy",         32'(bus.busy), 0);
        check("rst_done",         32'(bus.done), 0);
        check("rst_frag_valid",   32'(bus.frag_valid), 0);
        check("rst_frag_x",       32'(bus.frag_x), 0);
        check("rst_frag_y",       32'(bus.frag_y), 0);
        check("rst_frag_z",       32'(bus.frag_z), 0);
        check("rst_interp_point", 32'(bus.interp_point), 0);
        check("rst_interp_tri",   32'(bus.interp_tri != '0), 0);
    endtask

    task automatic compare_frags(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_x"}, 32'(got_q[i].x), 32'(exp_q[i].x));
            check({tag, "_y"}, 32'(got_q[i].y), 32'(exp_q[i].y));
            check({tag, "_z"}, 32'(got_q[i].z), 32'(exp_q[i].z));
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after done (or after abort_after fragments).
    task automatic run_tri(input triangle3d_t t, input int stall_idx, input int stall_len,
                           input bit rand_rdy, input int abort_after);
        int nacc, stall_cnt, last_acc;
        bit saw_done, aborted, stalling;
        logic signed [15:0] hx, hy;
        logic [7:0] hz;
        got_q.delete();
        done_cnt = 0; done_cyc = -1; first_vld_cyc = -1; last_acc = -10;
        nacc = 0; stall_cnt = 0; saw_done = 0; aborted = 0;
        hx = '0; hy = '0; hz = '0;
        check("pre_tri_ready", 32'(bus.tri_ready), 1);
        bus.tri_in = t;
        bus.tri_valid = 1'b1;
        @(posedge clk); #1;
        bus.tri_valid = 1'b0;
        bus.tri_in = '0;
        for (int cyc = 1; cyc <= 1500; cyc++) begin
            if (bus.frag_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            stalling = (stall_len > 0) && (nacc == stall_idx) && (stall_cnt < stall_len) &&
                       (stall_cnt > 0 || bus.frag_valid);
            if (stalling) begin
                if (stall_cnt == 0) begin
                    hx = bus.frag_x; hy = bus.frag_y; hz = bus.frag_z;
                end else begin
                    check("stall_valid", 32'(bus.frag_valid), 1);
                    check("stall_x", 32'(bus.frag_x), 32'(hx));
                    check("stall_y", 32'(bus.frag_y), 32'(hy));
                    check("stall_z", 32'(bus.frag_z), 32'(hz));
                end
                stall_cnt++;
                bus.frag_ready = 1'b0;
            end else begin
                bus.frag_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (rand_rdy) begin
                bus.tri_valid = $urandom_range(0, 1) != 0;
                bus.tri_in = mk_tri(int'($urandom_range(0, 15)), 0, 0, int'($urandom_range(0, 15)), 9, 9);
            end
            check("busy_high", 32'(bus.busy), 1);
            check("tri_ready_low", 32'(bus.tri_ready), 0);
            if (bus.frag_valid && bus.frag_ready) begin
                if (stall_len > 0 && nacc == stall_idx)
                    check("stall_release_x", 32'(bus.frag_x), 32'(hx));
                check("frag_gap", 32'(cyc - last_acc >= 2), 1);
                last_acc = cyc;
                got_q.push_back('{x: bus.frag_x, y: bus.frag_y, z: bus.frag_z});
                nacc++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                saw_done = 1;
                bus.tri_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (saw_done) break;
            if (abort_after > 0 && nacc >= abort_after) begin
                aborted = 1;
                break;
            end
        end
        bus.frag_ready = 1'b1;
        bus.tri_valid = 1'b0;
        check("run_finished", 32'(saw_done || aborted), 1);
        if (saw_done) begin
            check("post_done_low", 32'(bus.done), 0);
            check("post_tri_ready", 32'(bus.tri_ready), 1);
            check("post_busy_low", 32'(bus.busy), 0);
        end
    endtask

    initial begin
        triangle3d_t t;
        int px, py, qx, qy, rx, ry;
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b1;
        bus.tri_valid = 1'b0;
        bus.tri_in = '0;
        bus.frag_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check_reset_state();
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic right triangle: 15 pixels with x+y<=4.
        t = mk_tri(0, 0, 4, 0, 0, 4);
        build_expected(t);
        run_tri(t, -1, 0, 1'b0, 0);
        check("basic_count", got_q.size(), 15);
        compare_frags("basic");
        check("basic_done_cnt", done_cnt, 1);
        check("basic_first_lat_ge3", 32'(first_vld_cyc >= 3), 1);
        check("basic_interp_tri", 32'(bus.interp_tri == t), 1);

        // Collinear vertices: no fragments, done two cycles after accept.
        t = mk_tri(0, 0, 2, 2, 4, 4);
        build_expected(t);
        run_tri(t, -1, 0, 1'b0, 0);
        check("degen_count", got_q.size(), 0);
        check("degen_done_cyc", done_cyc, 2);

        // Triangle larger than the screen, clipped to the first quadrant.
        t = mk_tri(-10, -10, 20, -10, -10, 20);
        build_expected(t);
        run_tri(t, -1, 0, 1'b0, 0);
        check("clip_count", got_q.size(), 66);
        compare_frags("clip");
        foreach (got_q[i])
            check("clip_in_range", 32'(got_q[i].x >= 0 && got_q[i].y >= 0 &&
                                       got_q[i].x + got_q[i].y <= 10), 1);

        // Backpressure on the third fragment for five cycles.
        t = mk_tri(0, 0, 4, 0, 0, 4);
        build_expected(t);
        run_tri(t, 2, 5, 1'b0, 0);
        check("bp_count", got_q.size(), 15);
        compare_frags("bp");

        // Asynchronous reset after the fourth fragment, then a full rerun.
        run_tri(t, -1, 0, 1'b0, 4);
        check("abort_partial", got_q.size(), 4);
        reset_n = 1'b0;
        #1;
        check_reset_state();
        @(posedge clk); #1;
        check("abort_no_done_a", 32'(bus.done), 0);
        @(posedge clk); #1;
        check("abort_no_done_b", 32'(bus.done), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("abort_no_done_c", 32'(bus.done), 0);
        build_expected(t);
        run_tri(t, -1, 0, 1'b0, 0);
        check("rerun_count", got_q.size(), 15);
        compare_frags("rerun");

        // Clockwise winding.
        t = mk_tri(0, 0, 0, 4, 4, 0);
        build_expected(t);
        run_tri(t, -1, 0, 1'b0, 0);
`ifdef BACKFACE_CULL_EN
        check("cw_count", got_q.size(), 0);
`else
        check("cw_count", got_q.size(), 15);
`endif
        compare_frags("cw");
        check("cw_done_cnt", done_cnt, 1);

        // Random triangles around the screen edges with random backpressure.
        for (int k = 0; k < 25; k++) begin
            px = int'($urandom_range(0, 27)) - 6; py = int'($urandom_range(0, 27)) - 6;
            qx = int'($urandom_range(0, 27)) - 6; qy = int'($urandom_range(0, 27)) - 6;
            rx = int'($urandom_range(0, 27)) - 6; ry = int'($urandom_range(0, 27)) - 6;
            t = mk_tri(px, py, qx, qy, rx, ry);
            build_expected(t);
            run_tri(t, -1, 0, 1'b1, 0);
            compare_frags("rand");
            check("rand_done_cnt", done_cnt, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
